uart_tx_core: RTL

UART_TX_CORE -- requirements
Module: uart_tx_core

---
 rtl/uart_tx_core_if.sv | 39 +++
 rtl/uart_tx_core.sv | 102 ++++++++++
 2 files changed

// File: rtl/uart_tx_core_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_core_if
// Description : Payload/strobe/serial-line bundle between a UART TX core and
//               the logic that feeds it.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_core_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  Data_Valid;
   logic                  PAR_EN;
   logic                  parity;
   logic                  TX_OUT;
   logic                  busy;
   logic                  frame_done;

   modport master (
      output P_DATA,
      output Data_Valid,
      output PAR_EN,
      output parity,
      input  TX_OUT,
      input  busy,
      input  frame_done
   );

   modport slave (
      input  P_DATA,
      input  Data_Valid,
      input  PAR_EN,
      input  parity,
      output TX_OUT,
      output busy,
      output frame_done
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_core
// Description : UART frame serializer: start bit, LSB-first payload, optional
//               parity bit, stop bit; back-to-back frames with no idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_core #(
   parameter int DATA_WIDTH = 8
) (
   input  logic          CLK,
   input  logic          RST,
   uart_tx_core_if.slave bus
);
   localparam int c_CNT_W = $clog2(DATA_WIDTH);
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DATA_WIDTH - 1);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_START  = 3'd1;
   localparam logic [2:0] c_DATA   = 3'd2;
   localparam logic [2:0] c_PARITY = 3'd3;
   localparam logic [2:0] c_STOP   = 3'd4;

   logic [2:0]            r_state;
   logic [c_CNT_W-1:0]    r_cnt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_par_en;
   logic                  r_tx;
   logic                  r_busy;
   logic                  r_frame_done;
   logic                  w_accept;

   assign w_accept = bus.Data_Valid && ((r_state == c_IDLE) || (r_state == c_STOP));

   // TX_OUT is loaded with the level of the state being entered, so the line
   // only moves on state-change edges.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state      <= c_IDLE;
         r_cnt        <= '0;
         r_shift      <= '0;
         r_par_en     <= 1'b0;
         r_tx         <= 1'b1;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            c_IDLE, c_STOP: begin
               if (w_accept) begin
                  r_state  <= c_START;
                  r_shift  <= bus.P_DATA;
                  r_par_en <= bus.PAR_EN;
                  r_tx     <= 1'b0;
                  r_busy   <= 1'b1;
               end else begin
                  r_state  <= c_IDLE;
                  r_tx     <= 1'b1;
                  r_busy   <= 1'b0;
               end
            end
            c_START: begin
               r_state <= c_DATA;
               r_cnt   <= '0;
               r_tx    <= r_shift[0];
               r_shift <= r_shift >> 1;
            end
            c_DATA: begin
               if (r_cnt == c_LAST) begin
                  if (r_par_en) begin
                     r_state <= c_PARITY;
                     r_tx    <= bus.parity;
                  end else begin
                     r_state      <= c_STOP;
                     r_tx         <= 1'b1;
                     r_frame_done <= 1'b1;
                  end
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
                  r_tx    <= r_shift[0];
                  r_shift <= r_shift >> 1;
               end
            end
            c_PARITY: begin
               r_state      <= c_STOP;
               r_tx         <= 1'b1;
               r_frame_done <= 1'b1;
            end
            default: begin
               r_state <= c_IDLE;
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.TX_OUT     = r_tx;
   assign bus.busy       = r_busy;
   assign bus.frame_done = r_frame_done;
endmodule
`default_nettype wire
